// File: rtl/step_debounce.sv
// rtl/step_debounce.sv - step push-button debouncer and CPU clock-enable generator
// Debounces a raw button on divider ticks and issues single-step or free-run step enables.
module step_debounce #(
    parameter int STABLE_SAMPLES = 3
) (
    input  logic       Origin_Clock,
    input  logic       reset,
    input  logic       pulse,
    input  logic       button,
    input  logic       run,
    output logic       step_en,
    output logic       btn_level,
    output logic [7:0] step_count
);

    typedef enum logic [1:0] {
        RELEASED      = 2'd0,
        PRESS_CHECK   = 2'd1,
        PRESSED       = 2'd2,
        RELEASE_CHECK = 2'd3
    } state_t;

    localparam logic [4:0] STABLE_N = 5'(STABLE_SAMPLES);

    logic       btn_meta_q, btn_s_q, run_meta_q, run_s_q;
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       btn_level_q, btn_level_d;
    logic       step_en_q, step_en_d;
    logic [7:0] step_count_q, step_count_d;
    logic [4:0] cnt_inc;
    logic       press_evt;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_evt = 1'b0;
        cnt_inc   = {1'b0, cnt_q} + 5'd1;
        case (state_q)
            RELEASED: begin
                if (pulse && btn_s_q) begin
                    state_d = PRESS_CHECK;
                    cnt_d   = 4'd1;
                end
            end
            PRESS_CHECK: begin
                if (pulse) begin
                    if (!btn_s_q) begin
                        state_d = RELEASED;
                        cnt_d   = 4'd0;
                    end else if (cnt_inc == STABLE_N) begin
                        state_d   = PRESSED;
                        cnt_d     = 4'd0;
                        press_evt = 1'b1;
                    end else begin
                        cnt_d = cnt_inc[3:0];
                    end
                end
            end
            PRESSED: begin
                if (pulse && !btn_s_q) begin
                    state_d = RELEASE_CHECK;
                    cnt_d   = 4'd1;
                end
            end
            RELEASE_CHECK: begin
                if (pulse) begin
                    if (btn_s_q) begin
                        state_d = PRESSED;
                        cnt_d   = 4'd0;
                    end else if (cnt_inc == STABLE_N) begin
                        state_d = RELEASED;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_inc[3:0];
                    end
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = 4'd0;
            end
        endcase
        btn_level_d  = (state_d == PRESSED) || (state_d == RELEASE_CHECK);
        // Free-run steps on every tick; single-step only on an accepted press.
        step_en_d    = run_s_q ? pulse : press_evt;
        step_count_d = step_count_q + {7'd0, step_en_q};
    end

    always_ff @(posedge Origin_Clock or posedge reset) begin
        if (reset) begin
            btn_meta_q   <= 1'b0;
            btn_s_q      <= 1'b0;
            run_meta_q   <= 1'b0;
            run_s_q      <= 1'b0;
            state_q      <= RELEASED;
            cnt_q        <= 4'd0;
            btn_level_q  <= 1'b0;
            step_en_q    <= 1'b0;
            step_count_q <= 8'd0;
        end else begin
            btn_meta_q   <= button;
            btn_s_q      <= btn_meta_q;
            run_meta_q   <= run;
            run_s_q      <= run_meta_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            btn_level_q  <= btn_level_d;
            step_en_q    <= step_en_d;
            step_count_q <= step_count_d;
        end
    end

    assign step_en    = step_en_q;
    assign btn_level  = btn_level_q;
    assign step_count = step_count_q;

endmodule

// File: tb/tb_step_debounce.sv
// tb/tb_step_debounce.sv - scoreboard bench for step_debounce
// Reference model tracks a streak of ticks disagreeing with the accepted level.
module tb_step_debounce;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pulse = 1'b0;
    logic       button = 1'b0;
    logic       run = 1'b0;
    logic       step_en, btn_level;
    logic [7:0] step_count;

    step_debounce #(.STABLE_SAMPLES(N)) dut (
        .Origin_Clock(clk),
        .reset(reset),
        .pulse(pulse),
        .button(button),
        .run(run),
        .step_en(step_en),
        .btn_level(btn_level),
        .step_count(step_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int edge_i;
        int val;
    } ev_t;

    ev_t step_q[$];
    ev_t lvl_q[$];
    ev_t mon_e;

    int total = 0;
    int bad = 0;

    int m_lvl = 0, m_streak = 0, m_count = 0;
    bit m_b1 = 0, m_bs = 0, m_r1 = 0, m_rs = 0;
    bit in_b = 0, in_r = 0, in_p = 0;
    int last_lvl = 0;

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Applies the edge that just occurred, using the inputs that were present before it.
    task automatic model_edge();
        bit press;
        bit exp_step;
        int old_lvl;
        press = 0;
        old_lvl = m_lvl;
        if (in_p) begin
            if (int'(m_bs) != m_lvl) begin
                m_streak++;
                if (m_streak == N) begin
                    m_lvl = 1 - m_lvl;
                    m_streak = 0;
                    press = (m_lvl == 1);
                end
            end else begin
                m_streak = 0;
            end
        end
        exp_step = m_rs ? in_p : press;
        if (exp_step) begin
            step_q.push_back('{edge_i: cyc, val: m_count});
            m_count = (m_count + 1) % 256;
        end
        if (m_lvl != old_lvl) lvl_q.push_back('{edge_i: cyc, val: m_lvl});
        m_bs = m_b1;
        m_b1 = in_b;
        m_rs = m_r1;
        m_r1 = in_r;
    endtask

    task automatic step(input bit b, input bit r, input bit p);
        @(posedge clk);
        #1;
        model_edge();
        button = b;
        run = r;
        pulse = p;
        in_b = b;
        in_r = r;
        in_p = p;
    endtask

    task automatic ticks(input bit b, input bit r, input int n, input int gap);
        for (int t = 0; t < n; t++) begin
            step(b, r, 1'b1);
            repeat (gap) step(b, r, 1'b0);
        end
    endtask

    task automatic settle();
        repeat (6) step(in_b, in_r, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_step_en", int'(step_en), 0);
        check("rst_btn_level", int'(btn_level), 0);
        check("rst_step_count", int'(step_count), 0);
        m_lvl = 0; m_streak = 0; m_count = 0;
        m_b1 = 0; m_bs = 0; m_r1 = 0; m_rs = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                last_lvl = 0;
            end else begin
                while (step_q.size() > 0 && step_q[0].edge_i < cyc) begin
                    mon_e = step_q.pop_front();
                    check("step_missed", 0, 1);
                end
                if (step_en) begin
                    if (step_q.size() == 0) begin
                        check("step_unexpected", 1, 0);
                    end else begin
                        mon_e = step_q.pop_front();
                        check("step_edge", cyc, mon_e.edge_i);
                        check("step_count_at_step", int'(step_count), mon_e.val);
                    end
                end
                while (lvl_q.size() > 0 && lvl_q[0].edge_i < cyc) begin
                    mon_e = lvl_q.pop_front();
                    check("lvl_missed", last_lvl, mon_e.val);
                end
                if (int'(btn_level) != last_lvl) begin
                    if (lvl_q.size() == 0) begin
                        check("lvl_unexpected", int'(btn_level), last_lvl);
                    end else begin
                        mon_e = lvl_q.pop_front();
                        check("lvl_edge", cyc, mon_e.edge_i);
                        check("lvl_val", int'(btn_level), mon_e.val);
                    end
                end
                last_lvl = int'(btn_level);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();

        // Button held over five ticks in single-step mode.
        repeat (3) step(1'b1, 1'b0, 1'b0);
        ticks(1'b1, 1'b0, 5, 3);
        settle();
        check("held_count", int'(step_count), 1);
        check("held_level", int'(btn_level), 1);

        // Bouncing button never reaches the pressed state.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            repeat (3) step(i[0] ? 1'b0 : 1'b1, 1'b0, 1'b0);
            step(i[0] ? 1'b0 : 1'b1, 1'b0, 1'b1);
        end
        settle();
        check("bounce_count", int'(step_count), 0);
        check("bounce_level", int'(btn_level), 0);

        // Free-run with idle button.
        do_reset();
        repeat (3) step(1'b0, 1'b1, 1'b0);
        ticks(1'b0, 1'b1, 10, 2);
        settle();
        check("freerun_count", int'(step_count), 10);

        // 255 presses then one more wraps the counter.
        do_reset();
        for (int i = 0; i < 255; i++) begin
            ticks(1'b1, 1'b0, 5, 1);
            ticks(1'b0, 1'b0, 5, 1);
        end
        settle();
        check("count_255", int'(step_count), 255);
        ticks(1'b1, 1'b0, 5, 1);
        ticks(1'b0, 1'b0, 5, 1);
        settle();
        check("count_wrap", int'(step_count), 0);

        // Reset in PRESS_CHECK with two samples taken, button still held.
        do_reset();
        repeat (3) step(1'b1, 1'b0, 1'b0);
        ticks(1'b1, 1'b0, 2, 1);
        do_reset();
        repeat (3) step(1'b1, 1'b0, 1'b0);
        ticks(1'b1, 1'b0, 2, 1);
        settle();
        check("after_rst_2ticks", int'(step_count), 0);
        ticks(1'b1, 1'b0, 1, 1);
        settle();
        check("after_rst_3ticks", int'(step_count), 1);

        // Switch to free-run while the button is held down.
        do_reset();
        repeat (3) step(1'b1, 1'b0, 1'b0);
        ticks(1'b1, 1'b0, 4, 1);
        repeat (5) step(1'b1, 1'b1, 1'b0);
        check("switch_no_extra", int'(step_count), 1);
        ticks(1'b1, 1'b1, 4, 2);
        settle();
        check("switch_count", int'(step_count), 5);

        // Randomized traffic with occasional asynchronous resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit nb, nr, np;
            nb = ($urandom_range(0, 7) == 0) ? ~in_b : in_b;
            nr = ($urandom_range(0, 99) == 0) ? ~in_r : in_r;
            np = ($urandom_range(0, 2) == 0);
            step(nb, nr, np);
            if ($urandom_range(0, 499) == 0) do_reset();
        end
        settle();
        check("rand_count", int'(step_count), m_count);
        check("rand_level", int'(btn_level), m_lvl);
        check("step_q_empty", step_q.size(), 0);
        check("lvl_q_empty", lvl_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
